// File: rtl/dbus_sram_responder_if.sv
`default_nettype none
// dbus_sram_responder_if: data-bus request/response bundle between requester and SRAM responder.
// Rev 1.0
interface dbus_sram_responder_if;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface
`default_nettype wire

// File: rtl/dbus_sram_responder.sv
`default_nettype none
// dbus_sram_responder: single-outstanding data-bus responder backed by a 64-bit
// byte-strobed SRAM with a fixed response latency.  Rev 1.0
module dbus_sram_responder #(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  dbus_sram_responder_if.slave bus,
  output logic                 busy,
  output logic                 err,
  output logic [31:0]          done_cnt
);
  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   addr_q;
  logic [63:0]   data_q;
  logic [7:0]    strobe_q;
  logic [63:0]   mem [DEPTH];

  logic [63:0]   look_addr;
  logic          look_hit;
  logic [63:0]   look_word;
  logic          enter_resp;
  logic          unused_size;

  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < SPAN);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [63:0] a);
    return AW'((a - BASE) >> 3);
  endfunction

  // With LATENCY==1 RESP is entered straight from IDLE, before addr_q is loaded.
  assign look_addr  = (state == IDLE) ? bus.dreq.addr : addr_q;
  assign look_hit   = in_range(look_addr);
  assign look_word  = look_hit ? mem[word_idx(look_addr)] : 64'd0;
  assign enter_resp = ((state == IDLE) && bus.dreq.valid && (LATENCY == 1)) ||
                      ((state == WAIT) && (cnt == CW'(1)));
  assign unused_size = ^bus.dreq.size;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      done_cnt  <= '0;
      bus.dresp <= '0;
    end else begin
      bus.dresp.addr_ok <= 1'b0;
      bus.dresp.data_ok <= 1'b0;
      if (enter_resp) begin
        bus.dresp.addr_ok <= 1'b1;
        bus.dresp.data_ok <= 1'b1;
        bus.dresp.data    <= look_word;
        if (!look_hit) err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (bus.dreq.valid) begin
            addr_q   <= bus.dreq.addr;
            strobe_q <= bus.dreq.strobe;
            data_q   <= bus.dreq.data;
            busy     <= 1'b1;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              cnt   <= CW'(LATENCY - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= RESP;
        end
        RESP: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done_cnt <= done_cnt + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset; a write still in RESP when reset arrives is dropped.
  always_ff @(posedge clk) begin
    if (!reset && (state == RESP) && (strobe_q != 8'd0) && in_range(addr_q)) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem[word_idx(addr_q)][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end
endmodule
`default_nettype wire
